// File: rtl/jtframe_data_io_if.sv
// Download bus bundle: SPI lines from the MiST I/O controller and the byte-wide ioctl bus to the core.
// dl_sum is present only when JTFRAME_DL_SUM_EN is defined.
interface jtframe_data_io_if #(
   parameter int AW = 22
);
   logic          SPI_SCK;
   logic          SPI_SS2;
   logic          SPI_DI;
   logic          downloading;
   logic [7:0]    ioctl_index;
   logic [AW-1:0] ioctl_addr;
   logic [7:0]    ioctl_data;
   logic          ioctl_wr;
`ifdef JTFRAME_DL_SUM_EN
   logic [15:0]   dl_sum;

   modport slave (
      input  SPI_SCK, SPI_SS2, SPI_DI,
      output downloading, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, dl_sum
   );
   modport master (
      output SPI_SCK, SPI_SS2, SPI_DI,
      input  downloading, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, dl_sum
   );
`else
   modport slave (
      input  SPI_SCK, SPI_SS2, SPI_DI,
      output downloading, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr
   );
   modport master (
      output SPI_SCK, SPI_SS2, SPI_DI,
      input  downloading, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr
   );
`endif
endinterface

// File: rtl/jtframe_data_io.sv
// Oversampled SPI download responder: MiST ARM file transfers become ioctl byte writes.
// Define JTFRAME_DL_SUM_EN to add a 16-bit additive checksum of the strobed bytes on dl_sum.
module jtframe_data_io #(
   parameter int AW = 22
) (
   input  logic             clk,
   input  logic             rst,
   jtframe_data_io_if.slave bus
);

   typedef enum logic [2:0] {ST_CMD, ST_TXCTL, ST_INDEX, ST_DATA, ST_SKIP} state_t;

   localparam logic [7:0] CMD_TXCTL = 8'h53;
   localparam logic [7:0] CMD_DATA  = 8'h54;
   localparam logic [7:0] CMD_INDEX = 8'h55;

   logic [1:0]    sck_sync, ss2_sync, di_sync;
   logic          sck_last;
   logic          sck_rise;
   logic          ss_idle;
   logic [6:0]    shift;
   logic [2:0]    bit_cnt;
   logic          byte_valid;
   logic [7:0]    rx_byte;
   state_t        state;
   logic [AW-1:0] dl_cnt;

   assign sck_rise = sck_sync[1] & ~sck_last;
   assign ss_idle  = ss2_sync[1];

   // SS2 resets to "deselected" so nothing shifts until the controller really drives it low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync <= '0;
         ss2_sync <= '1;
         di_sync  <= '0;
         sck_last <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old value of its neighbour,
         // which is what turns this chain into a real two-stage synchronizer.
         sck_sync <= {sck_sync[0], bus.SPI_SCK};
         ss2_sync <= {ss2_sync[0], bus.SPI_SS2};
         di_sync  <= {di_sync[0],  bus.SPI_DI};
         sck_last <= sck_sync[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift      <= '0;
         bit_cnt    <= '0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
      end else begin
         byte_valid <= 1'b0;
         if (ss_idle) begin
            bit_cnt <= '0;
         end else if (sck_rise) begin
            shift   <= {shift[5:0], di_sync[1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_byte    <= {shift, di_sync[1]};
               byte_valid <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_CMD;
         dl_cnt          <= '0;
         bus.downloading <= 1'b0;
         bus.ioctl_index <= '0;
         bus.ioctl_addr  <= '0;
         bus.ioctl_data  <= '0;
         bus.ioctl_wr    <= 1'b0;
`ifdef JTFRAME_DL_SUM_EN
         bus.dl_sum      <= '0;
`endif
      end else begin
         bus.ioctl_wr <= 1'b0;
         if (byte_valid) begin
            unique case (state)
               ST_CMD: begin
                  case (rx_byte)
                     CMD_TXCTL: state <= ST_TXCTL;
                     CMD_DATA:  state <= ST_DATA;
                     CMD_INDEX: state <= ST_INDEX;
                     default:   state <= ST_SKIP;
                  endcase
               end
               ST_TXCTL: begin
                  if (rx_byte == 8'hFF) begin
                     bus.downloading <= 1'b1;
                     dl_cnt          <= '0;
`ifdef JTFRAME_DL_SUM_EN
                     bus.dl_sum      <= '0;
`endif
                  end else if (rx_byte == 8'h00) begin
                     bus.downloading <= 1'b0;
                  end
                  state <= ST_SKIP;
               end
               ST_INDEX: begin
                  bus.ioctl_index <= rx_byte;
                  state           <= ST_SKIP;
               end
               ST_DATA: begin
                  // Data streams until SS2 rises; the counter wraps freely at 2^AW.
                  if (bus.downloading) begin
                     bus.ioctl_data <= rx_byte;
                     bus.ioctl_addr <= dl_cnt;
                     bus.ioctl_wr   <= 1'b1;
                     dl_cnt         <= dl_cnt + AW'(1);
`ifdef JTFRAME_DL_SUM_EN
                     bus.dl_sum     <= bus.dl_sum + {8'd0, rx_byte};
`endif
                  end
               end
               default: ;
            endcase
         end
         // Deselect always wins, so a frame end can never leave the FSM mid-command.
         if (ss_idle) state <= ST_CMD;
      end
   end

endmodule

// File: tb/tb_jtframe_data_io.sv
// Bench for jtframe_data_io: one AW=22 and one AW=4 instance share the same SPI stimulus,
// checked against a frame-level model of the download protocol.
module tb_jtframe_data_io;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sck = 1'b0;
   logic ss2 = 1'b1;
   logic di  = 1'b0;

   always #5 clk = ~clk;

   jtframe_data_io_if #(.AW(22)) bus_a ();
   jtframe_data_io_if #(.AW(4))  bus_b ();

   assign bus_a.SPI_SCK = sck;
   assign bus_a.SPI_SS2 = ss2;
   assign bus_a.SPI_DI  = di;
   assign bus_b.SPI_SCK = sck;
   assign bus_b.SPI_SS2 = ss2;
   assign bus_b.SPI_DI  = di;

   jtframe_data_io #(.AW(22)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   jtframe_data_io #(.AW(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   int checks = 0;
   int errors = 0;
   int wr_seen_a = 0;
   int wr_seen_b = 0;
   int exp_writes = 0;

   // Protocol model state
   bit          m_dl;
   logic [7:0]  m_idx;
   int          m_cnt;
   int          m_last;
   logic [15:0] m_sum;

   logic [7:0] fr [32];
   int         fr_len;
   int         fr_cut;

   typedef struct {
      int          len;
      logic [31:0] bytes;
      int          cut;
      logic        dl;
      logic [7:0]  idx;
      logic [21:0] addr;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (bus_a.ioctl_wr) wr_seen_a <= wr_seen_a + 1;
      if (bus_b.ioctl_wr) wr_seen_b <= wr_seen_b + 1;
   end

   // Mode 0, MSB first, 4 clk per SCK phase; called right after a negedge.
   task automatic send_byte(input logic [7:0] b, input int nbits, input bit exp_wr, input int exp_addr);
      for (int k = 0; k < nbits; k++) begin
         sck = 1'b0;
         di  = b[7-k];
         repeat (4) @(negedge clk);
         sck = 1'b1;
         if (k == 7) begin
            repeat (3) @(posedge clk);
            #1 check("wr_early", 32'(bus_a.ioctl_wr), 32'(1'b0));
            @(posedge clk);
            #1;
            check("wr_a", 32'(bus_a.ioctl_wr), 32'(exp_wr));
            check("wr_b", 32'(bus_b.ioctl_wr), 32'(exp_wr));
            if (exp_wr) begin
               check("addr_a", 32'(bus_a.ioctl_addr), 32'(exp_addr % (1 << 22)));
               check("addr_b", 32'(bus_b.ioctl_addr), 32'(exp_addr % 16));
               check("data_a", 32'(bus_a.ioctl_data), 32'(b));
               check("data_b", 32'(bus_b.ioctl_data), 32'(b));
            end
            @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
      end
      sck = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input string name);
      logic [7:0] cmd;
      bit         full;
      bit         wr_e;
      bit         param_ok;
      @(negedge clk);
      ss2 = 1'b0;
      cmd = fr[0];
      for (int i = 0; i < fr_len; i++) begin
         full = !(i == fr_len - 1 && fr_cut < 8);
         wr_e = full && cmd == 8'h54 && i > 0 && m_dl;
         send_byte(fr[i], full ? 8 : fr_cut, wr_e, m_cnt);
         if (wr_e) begin
            m_last = m_cnt;
            m_cnt++;
            m_sum = m_sum + 16'(fr[i]);
            exp_writes++;
         end
      end
      param_ok = fr_len > 2 || (fr_len == 2 && fr_cut >= 8);
      if (param_ok && cmd == 8'h53) begin
         if (fr[1] == 8'hFF) begin
            m_dl  = 1'b1;
            m_cnt = 0;
            m_sum = '0;
         end else if (fr[1] == 8'h00) begin
            m_dl = 1'b0;
         end
      end
      if (param_ok && cmd == 8'h55) m_idx = fr[1];
      ss2 = 1'b1;
      repeat (6) @(negedge clk);
      check({name, " downloading"}, 32'(bus_a.downloading), 32'(m_dl));
      check({name, " downloading_b"}, 32'(bus_b.downloading), 32'(m_dl));
      check({name, " index"}, 32'(bus_a.ioctl_index), 32'(m_idx));
      check({name, " addr_a"}, 32'(bus_a.ioctl_addr), 32'(m_last % (1 << 22)));
      check({name, " addr_b"}, 32'(bus_b.ioctl_addr), 32'(m_last % 16));
      check({name, " wr_count_a"}, 32'(wr_seen_a), 32'(exp_writes));
      check({name, " wr_count_b"}, 32'(wr_seen_b), 32'(exp_writes));
`ifdef JTFRAME_DL_SUM_EN
      check({name, " dl_sum_a"}, 32'(bus_a.dl_sum), 32'(m_sum));
      check({name, " dl_sum_b"}, 32'(bus_b.dl_sum), 32'(m_sum));
`endif
   endtask

   task automatic model_reset();
      m_dl   = 1'b0;
      m_idx  = '0;
      m_cnt  = 0;
      m_last = 0;
      m_sum  = '0;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " downloading"}, 32'(bus_a.downloading), 0);
      check({name, " index"}, 32'(bus_a.ioctl_index), 0);
      check({name, " addr_a"}, 32'(bus_a.ioctl_addr), 0);
      check({name, " data_a"}, 32'(bus_a.ioctl_data), 0);
      check({name, " wr_a"}, 32'(bus_a.ioctl_wr), 0);
      check({name, " addr_b"}, 32'(bus_b.ioctl_addr), 0);
      check({name, " downloading_b"}, 32'(bus_b.downloading), 0);
`ifdef JTFRAME_DL_SUM_EN
      check({name, " dl_sum_a"}, 32'(bus_a.dl_sum), 0);
`endif
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2, 32'h5502_0000, 8, 1'b0, 8'h02, 22'd0};
      vecs[1] = '{2, 32'h53FF_0000, 8, 1'b1, 8'h02, 22'd0};
      vecs[2] = '{4, 32'h54A5_3C7E, 8, 1'b1, 8'h02, 22'd2};
      vecs[3] = '{2, 32'h54FF_0000, 5, 1'b1, 8'h02, 22'd2};
      vecs[4] = '{2, 32'h5411_0000, 8, 1'b1, 8'h02, 22'd3};
      vecs[5] = '{2, 32'h5300_0000, 8, 1'b0, 8'h02, 22'd3};
      vecs[6] = '{2, 32'h5422_0000, 8, 1'b0, 8'h02, 22'd3};
      vecs[7] = '{2, 32'h9954_0000, 8, 1'b0, 8'h02, 22'd3};
      model_reset();

      // Reset held while SCK toggles
      repeat (8) begin
         @(negedge clk);
         sck = ~sck;
      end
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      sck = 1'b0;
      repeat (20) @(negedge clk);
      check("post_reset wr_count", 32'(wr_seen_a), 0);

      // Directed vectors
      for (int v = 0; v < 8; v++) begin
         fr_len = vecs[v].len;
         fr_cut = vecs[v].cut;
         for (int i = 0; i < 4; i++) fr[i] = vecs[v].bytes[31 - 8*i -: 8];
         send_frame($sformatf("vec%0d", v));
         check($sformatf("vec%0d tbl_downloading", v), 32'(bus_a.downloading), 32'(vecs[v].dl));
         check($sformatf("vec%0d tbl_index", v), 32'(bus_a.ioctl_index), 32'(vecs[v].idx));
         check($sformatf("vec%0d tbl_addr", v), 32'(bus_a.ioctl_addr), 32'(vecs[v].addr));
      end

      // Address wrap on the AW=4 instance: 17 bytes after a fresh start
      fr_len = 2; fr_cut = 8;
      fr[0] = 8'h53; fr[1] = 8'hFF;
      send_frame("wrap_start");
      fr_len = 18;
      fr[0] = 8'h54;
      for (int i = 1; i < 18; i++) fr[i] = 8'($urandom_range(0, 255));
      send_frame("wrap_data");
      check("wrap addr_b", 32'(bus_b.ioctl_addr), 0);
      check("wrap addr_a", 32'(bus_a.ioctl_addr), 16);
      check("wrap downloading_b", 32'(bus_b.downloading), 1);

      // Randomized frames
      for (int n = 0; n < 16; n++) begin
         int sel;
         fr_len = $urandom_range(2, 5);
         fr_cut = 8;
         for (int i = 1; i < fr_len; i++) fr[i] = 8'($urandom_range(0, 255));
         sel = $urandom_range(0, 5);
         case (sel)
            0, 1: fr[0] = 8'h54;
            2: begin
               fr[0] = 8'h53;
               fr[1] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'hFF;
            end
            3: fr[0] = 8'h53;
            4: fr[0] = 8'h55;
            default: fr[0] = 8'($urandom_range(0, 255));
         endcase
         send_frame($sformatf("rand%0d", n));
      end

      // Reset in the middle of a data byte
      fr_len = 2; fr_cut = 8;
      fr[0] = 8'h53; fr[1] = 8'hFF;
      send_frame("mid_start");
      @(negedge clk);
      ss2 = 1'b0;
      send_byte(8'h54, 8, 1'b0, 0);
      send_byte(8'h5A, 4, 1'b0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      ss2 = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      fr[0] = 8'h54; fr[1] = 8'hAA;
      send_frame("after_reset_nodl");
      fr[0] = 8'h53; fr[1] = 8'hFF;
      send_frame("after_reset_start");
      fr_len = 3;
      fr[0] = 8'h54; fr[1] = 8'hBB; fr[2] = 8'hCC;
      send_frame("after_reset_data");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
